reg_alu_seq: RTL and testbench
==============================

Name: reg_alu_seq

Overview:
- Instruction sequencer directly upstream of the reg_alu datapath; the only driver of its control and data-in ports.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Sequences each instruction through a fixed execute/writeback schedule, driving sel, wr, op, the three register addresses and d_in.
- Reports completion, a retired-instruction count and a halted flag.

Parameters:
- CNT_W, 8: width of retired-instruction counter instr_count (saturating).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction on instr is valid.
- in_ready  output  1  sequencer can accept an instruction this cycle.
- instr  input  16  instruction word.
- sel  output  1  reg_alu write-source select: 1 = external d_in, 0 = ALU result.
- wr  output  1  reg_alu register-file write enable.
- op  output  2  reg_alu ALU operation.
- rd_addr_a  output  3  reg_alu read port A address.
- rd_addr_b  output  3  reg_alu read port B address.
- wr_addr  output  3  reg_alu write address.
- d_in  output  16  reg_alu external data (immediate).
- done  output  1  one-cycle pulse: instruction retired.
- halted  output  1  HALT executed; sticky until reset.
- instr_count  output  CNT_W  retired ALU/LOADI/NOP count.

Behaviour:
- Handshake:
  - Transfer when in_valid && in_ready at a rising edge.
  - in_ready = (state == IDLE) && !reset, combinational from state.
  - instr is sampled only on transfer; otherwise ignored.
- Encoding, instr[15:14]:
  - 00 ALU: op = [13:12], rd_addr_a = [11:9], rd_addr_b = [8:6], wr_addr = [5:3]; [2:0] reserved, ignored.
  - 01 LOADI: wr_addr = [13:11]; d_in = zero-extended [10:0].
  - 10 NOP.
  - 11 HALT.
- States: IDLE, EXEC, WB, NOPC, HALT.
- IDLE:
  - On transfer of ALU or LOADI: go to EXEC. All decoded fields register at the same edge.
  - On NOP transfer: go to NOPC.
  - On HALT transfer: go to HALT.
- EXEC (1 cycle):
  - Decoded fields driven, wr = 0, to let the reg_alu read/ALU path settle.
  - ALU: sel = 0; d_in holds its previous value.
  - LOADI: sel = 1; rd_addr_a/rd_addr_b hold previous values; op holds.
  - Next state: WB.
- WB (1 cycle):
  - Same fields as EXEC, with wr = 1 and done = 1.
  - Register write occurs at the edge ending WB.
  - instr_count += 1 at that edge, saturating at 2^CNT_W - 1.
  - Next state: IDLE.
- NOPC (1 cycle): wr = 0, done = 1, count increments (saturating), next state IDLE.
- HALT: halted = 1, in_ready = 0, wr = 0, done = 0, not counted. Leaves only via reset.
- Timing:
  - ALU/LOADI accepted at edge E: wr is high exactly during cycle E+2; in_ready returns high in cycle E+3.
  - Throughput is one ALU/LOADI per 3 cycles and one NOP per 2 cycles.
  - No back-to-back acceptance.
- Output hold: sel, op, addresses and d_in are registered and hold their last driven value in IDLE, NOPC and HALT. wr is 0 in every state except WB.
- Reset (any state, including mid-EXEC/WB):
  - Next state IDLE.
  - sel, wr, op, all addresses, d_in, done, halted and instr_count = 0.
  - A write pending in WB is suppressed at the reset edge: the reset edge clears wr, no count.
  - in_ready is 0 while reset is high and 1 in the first cycle after reset is released.
- Simultaneous events: reset dominates a transfer in the same cycle, and that instruction is dropped.

Test Plan:
- Reset, then instr = 0x585A (LOADI r3, 0x05A) with in_valid held one cycle -> in_ready low 2 cycles; cycle E+1: sel = 1, wr_addr = 3, d_in = 0x005A, wr = 0; cycle E+2: wr = 1, done = 1; afterwards instr_count = 1.
- instr = 0x0650 (ALU op 0, a = 3, b = 1, w = 2) -> cycles E+1/E+2: sel = 0, op = 0, rd_addr_a = 3, rd_addr_b = 1, wr_addr = 2; wr high only in E+2. Repeat with 0x3657 (op 3, reserved bits = 7) -> op = 3, same addresses, reserved bits ignored.
- Two ALU instructions presented with in_valid held continuously -> second accepted exactly 3 cycles after the first; exactly two wr pulses, 3 cycles apart.
- Assert reset during the WB cycle of 0x585A -> wr = 0 at that edge, instr_count = 0, all outputs 0, in_ready = 1 the cycle after release.
- NOP 0x8000 then HALT 0xC000 -> NOP: done pulse, no wr, count = 1; HALT: halted = 1, in_ready = 0; further in_valid with 0x585A is ignored for 20 cycles, count stays 1; reset clears halted.
- CNT_W = 2, five NOPs -> instr_count sequence 1, 2, 3, 3, 3; done pulses five times.

Source files
------------

// File: rtl/reg_alu_seq_if.sv
// Instruction valid/ready handshake between an instruction source and reg_alu_seq.
// The source uses the master modport, the sequencer the slave modport.
interface reg_alu_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;

  modport master (output in_valid, output instr, input in_ready);
  modport slave  (input in_valid, input instr, output in_ready);
endinterface

// File: rtl/reg_alu_seq.sv
// Instruction sequencer for the reg_alu datapath: accepts 16-bit instructions,
// runs ALU/LOADI through an EXEC/WB schedule, and tracks retired count and HALT.
module reg_alu_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  reg_alu_seq_if.slave     in_if,
  output logic             sel,
  output logic             wr,
  output logic [1:0]       op,
  output logic [2:0]       rd_addr_a,
  output logic [2:0]       rd_addr_b,
  output logic [2:0]       wr_addr,
  output logic [15:0]      d_in,
  output logic             done,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    WB   = 3'd2,
    NOPC = 3'd3,
    HALT = 3'd4
  } state_t;

  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_LOADI = 2'b01;
  localparam logic [1:0] CLS_NOP   = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg;
  state_t           state_next;
  logic             in_ready_int;
  logic             transfer;
  logic [1:0]       cls;
  logic             sel_reg;
  logic [1:0]       op_reg;
  logic [2:0]       rd_addr_a_reg;
  logic [2:0]       rd_addr_b_reg;
  logic [2:0]       wr_addr_reg;
  logic [15:0]      d_in_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign cls      = in_if.instr[15:14];
  assign transfer = in_if.in_valid && in_ready_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (transfer) begin
          case (cls)
            CLS_ALU, CLS_LOADI: state_next = EXEC;
            CLS_NOP:            state_next = NOPC;
            default:            state_next = HALT;
          endcase
        end
      end
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      NOPC:    state_next = IDLE;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // wr/done are gated by reset so a WB cycle hit by reset never commits a write.
  always_comb begin
    in_ready_int = 1'b0;
    wr           = 1'b0;
    done         = 1'b0;
    halted       = 1'b0;
    case (state_reg)
      IDLE: in_ready_int = !reset;
      WB: begin
        wr   = !reset;
        done = !reset;
      end
      NOPC: done   = !reset;
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign in_if.in_ready = in_ready_int;

  // Decoded fields only change on a transfer; LOADI leaves op and read addresses alone,
  // ALU leaves d_in alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_reg       <= 1'b0;
      op_reg        <= 2'b00;
      rd_addr_a_reg <= 3'd0;
      rd_addr_b_reg <= 3'd0;
      wr_addr_reg   <= 3'd0;
      d_in_reg      <= 16'h0000;
    end else if (transfer) begin
      case (cls)
        CLS_ALU: begin
          sel_reg       <= 1'b0;
          op_reg        <= in_if.instr[13:12];
          rd_addr_a_reg <= in_if.instr[11:9];
          rd_addr_b_reg <= in_if.instr[8:6];
          wr_addr_reg   <= in_if.instr[5:3];
        end
        CLS_LOADI: begin
          sel_reg     <= 1'b1;
          wr_addr_reg <= in_if.instr[13:11];
          d_in_reg    <= {5'b00000, in_if.instr[10:0]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (done && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign sel         = sel_reg;
  assign op          = op_reg;
  assign rd_addr_a   = rd_addr_a_reg;
  assign rd_addr_b   = rd_addr_b_reg;
  assign wr_addr     = wr_addr_reg;
  assign d_in        = d_in_reg;
  assign instr_count = cnt_reg;

endmodule

// File: tb/tb_reg_alu_seq.sv
// Self-checking bench for reg_alu_seq: directed scenarios plus randomized instruction
// streams checked against a per-instruction behavioural model.
module tb_reg_alu_seq;
  localparam int CNT_W  = 8;
  localparam int CNT_W2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, reset2;
  reg_alu_seq_if if0 ();
  reg_alu_seq_if if2 ();

  logic             sel, wr, done, halted;
  logic [1:0]       op;
  logic [2:0]       rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0]      d_in;
  logic [CNT_W-1:0] instr_count;

  logic              sel_2, wr_2, done_2, halted_2;
  logic [1:0]        op_2;
  logic [2:0]        rd_addr_a_2, rd_addr_b_2, wr_addr_2;
  logic [15:0]       d_in_2;
  logic [CNT_W2-1:0] instr_count_2;

  reg_alu_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_if(if0),
    .sel(sel), .wr(wr), .op(op), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_addr(wr_addr), .d_in(d_in), .done(done), .halted(halted), .instr_count(instr_count)
  );

  reg_alu_seq #(.CNT_W(CNT_W2)) dut2 (
    .clk(clk), .reset(reset2), .in_if(if2),
    .sel(sel_2), .wr(wr_2), .op(op_2), .rd_addr_a(rd_addr_a_2), .rd_addr_b(rd_addr_b_2),
    .wr_addr(wr_addr_2), .d_in(d_in_2), .done(done_2), .halted(halted_2),
    .instr_count(instr_count_2)
  );

  int total = 0;
  int bad   = 0;

  logic        m_sel;
  logic [1:0]  m_op;
  logic [2:0]  m_a, m_b, m_w;
  logic [15:0] m_d;
  int          m_cnt;

  function automatic void model_reset();
    m_sel = 1'b0; m_op = 2'd0; m_a = 3'd0; m_b = 3'd0; m_w = 3'd0; m_d = 16'd0; m_cnt = 0;
  endfunction

  function automatic void model_accept(input logic [15:0] x);
    int v;
    v = int'(x);
    if (v / 16384 == 0) begin
      m_sel = 1'b0;
      m_op  = 2'((v / 4096) % 4);
      m_a   = 3'((v / 512) % 8);
      m_b   = 3'((v / 64) % 8);
      m_w   = 3'((v / 8) % 8);
    end else if (v / 16384 == 1) begin
      m_sel = 1'b1;
      m_w   = 3'((v / 2048) % 8);
      m_d   = 16'(v % 2048);
    end
  endfunction

  function automatic void model_retire();
    if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if0.in_valid = 1'b1;
    if0.instr = 16'h585A;
    tick();
    tick();
    total++; if (if0.in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready_low got %b expected 0", if0.in_ready);
    end
    total++; if ({sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, done, halted, instr_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got %h expected 0",
               {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, done, halted, instr_count});
    end
    model_reset();
    if0.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++; if (if0.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready got %b expected 1", if0.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_instr(input logic [15:0] x, input bit junk);
    bit is_nop;
    is_nop = (x[15:14] == 2'b10);
    if0.in_valid = 1'b1;
    if0.instr = x;
    total++; if (if0.in_ready !== 1'b1) begin
      bad++; $display("FAIL accept_ready instr=%h got %b expected 1", x, if0.in_ready);
    end
    @(posedge clk);
    model_accept(x);
    @(negedge clk);
    if (junk) if0.instr = 16'($urandom); else if0.in_valid = 1'b0;
    total++; if ({if0.in_ready, wr, done} !== {1'b0, 1'b0, is_nop}) begin
      bad++;
      $display("FAIL exec_ctl instr=%h got rdy/wr/done=%b expected %b", x, {if0.in_ready, wr, done}, {1'b0, 1'b0, is_nop});
    end
    total++; if ({sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in} !== {m_sel, m_op, m_a, m_b, m_w, m_d}) begin
      bad++;
      $display("FAIL exec_fields instr=%h got %h expected %h", x,
               {sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in}, {m_sel, m_op, m_a, m_b, m_w, m_d});
    end
    if (!is_nop) begin
      tick();
      if (junk) if0.instr = 16'($urandom);
      total++; if ({if0.in_ready, wr, done} !== 3'b011) begin
        bad++;
        $display("FAIL wb_ctl instr=%h got rdy/wr/done=%b expected 011", x, {if0.in_ready, wr, done});
      end
      total++; if ({sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in} !== {m_sel, m_op, m_a, m_b, m_w, m_d}) begin
        bad++;
        $display("FAIL wb_fields instr=%h got %h expected %h", x,
                 {sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in}, {m_sel, m_op, m_a, m_b, m_w, m_d});
      end
      total++; if (instr_count !== CNT_W'(m_cnt)) begin
        bad++;
        $display("FAIL wb_count instr=%h got %0d expected %0d", x, instr_count, m_cnt);
      end
    end
    @(posedge clk);
    model_retire();
    @(negedge clk);
    if0.in_valid = 1'b0;
    total++; if ({if0.in_ready, wr, done, halted} !== 4'b1000) begin
      bad++;
      $display("FAIL idle_ctl instr=%h got rdy/wr/done/halt=%b expected 1000", x, {if0.in_ready, wr, done, halted});
    end
    total++; if (instr_count !== CNT_W'(m_cnt)) begin
      bad++;
      $display("FAIL retire_count instr=%h got %0d expected %0d", x, instr_count, m_cnt);
    end
    $display("txn instr=%h wr_addr=%0d d_in=%h count=%0d", x, wr_addr, d_in, instr_count);
  endtask

  task automatic test_directed();
    test_instr(16'h585A, 1'b0);
    test_instr(16'h0650, 1'b0);
    test_instr(16'h3657, 1'b1);
    total++; if ({op, rd_addr_a, rd_addr_b, wr_addr, sel} !== {2'd3, 3'd3, 3'd1, 3'd2, 1'b0}) begin
      bad++;
      $display("FAIL alu_decode got %h expected %h", {op, rd_addr_a, rd_addr_b, wr_addr, sel},
               {2'd3, 3'd3, 3'd1, 3'd2, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    int wr_pulses;
    a = 16'($urandom) & 16'h3FFF;
    b = 16'($urandom) & 16'h3FFF;
    wr_pulses = 0;
    if0.in_valid = 1'b1;
    if0.instr = a;
    @(posedge clk);
    model_accept(a);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) if0.instr = b;
      if (k == 4) if0.in_valid = 1'b0;
      if (wr === 1'b1) wr_pulses++;
      total++; if ({if0.in_ready, wr} !== {(k == 3 || k >= 6), (k == 2 || k == 5)}) begin
        bad++;
        $display("FAIL b2b_cycle%0d got rdy/wr=%b expected %b", k, {if0.in_ready, wr},
                 {(k == 3 || k >= 6), (k == 2 || k == 5)});
      end
      if (k == 2 || k == 5) begin
        total++; if ({sel, op, rd_addr_a, rd_addr_b, wr_addr} !== {m_sel, m_op, m_a, m_b, m_w}) begin
          bad++;
          $display("FAIL b2b_fields cycle%0d got %h expected %h", k,
                   {sel, op, rd_addr_a, rd_addr_b, wr_addr}, {m_sel, m_op, m_a, m_b, m_w});
        end
      end
      @(posedge clk);
      if (k == 3) model_accept(b);
      if (k == 2 || k == 5) model_retire();
    end
    @(negedge clk);
    total++; if (wr_pulses != 2) begin
      bad++; $display("FAIL b2b_wr_pulses got %0d expected 2", wr_pulses);
    end
    total++; if (instr_count !== CNT_W'(m_cnt)) begin
      bad++;
      $display("FAIL b2b_count got %0d expected %0d", instr_count, m_cnt);
    end
    $display("txn b2b a=%h b=%h wr_pulses=%0d count=%0d", a, b, wr_pulses, instr_count);
  endtask

  task automatic test_reset_in_wb();
    if0.in_valid = 1'b1;
    if0.instr = 16'h585A;
    tick();
    if0.in_valid = 1'b0;
    tick();
    total++; if (wr !== 1'b1) begin
      bad++; $display("FAIL rst_wb_pre got wr=%b expected 1", wr);
    end
    reset = 1'b1;
    #1;
    total++; if ({wr, done} !== 2'b00) begin
      bad++; $display("FAIL rst_wb_suppress got wr/done=%b expected 00", {wr, done});
    end
    @(posedge clk);
    model_reset();
    @(negedge clk);
    total++; if ({if0.in_ready, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, done, halted, instr_count} !== '0) begin
      bad++;
      $display("FAIL rst_wb_outputs got %h expected 0",
               {if0.in_ready, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, done, halted, instr_count});
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++; if ({if0.in_ready, instr_count} !== {1'b1, CNT_W'(0)}) begin
      bad++;
      $display("FAIL rst_wb_release got rdy/count=%h expected %h", {if0.in_ready, instr_count}, {1'b1, CNT_W'(0)});
    end
    @(negedge clk);
    $display("txn reset_in_wb count=%0d", instr_count);
  endtask

  task automatic test_nop_halt();
    test_instr(16'h8000, 1'b0);
    total++; if (instr_count !== CNT_W'(1)) begin
      bad++; $display("FAIL nop_count got %0d expected 1", instr_count);
    end
    if0.in_valid = 1'b1;
    if0.instr = 16'hC000;
    tick();
    if0.instr = 16'h585A;
    total++; if ({halted, if0.in_ready, done, wr} !== 4'b1000) begin
      bad++;
      $display("FAIL halt_enter got halt/rdy/done/wr=%b expected 1000", {halted, if0.in_ready, done, wr});
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if ({halted, if0.in_ready, done, wr, instr_count} !== {4'b1000, CNT_W'(1)}) begin
        bad++;
        $display("FAIL halt_hold cycle%0d got %h expected %h", i,
                 {halted, if0.in_ready, done, wr, instr_count}, {4'b1000, CNT_W'(1)});
      end
    end
    total++; if ({sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in} !== {m_sel, m_op, m_a, m_b, m_w, m_d}) begin
      bad++;
      $display("FAIL halt_fields got %h expected %h",
               {sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in}, {m_sel, m_op, m_a, m_b, m_w, m_d});
    end
    if0.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    model_reset();
    reset = 1'b0;
    total++; if ({halted, instr_count} !== {1'b0, CNT_W'(0)}) begin
      bad++;
      $display("FAIL halt_reset got halt/count=%h expected 0", {halted, instr_count});
    end
    $display("txn halt cleared halted=%b", halted);
  endtask

  task automatic test_saturate();
    int dones;
    int exp;
    dones = 0;
    if2.in_valid = 1'b0;
    if2.instr = 16'h8000;
    reset2 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if2.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if2.in_valid = 1'b0;
      if (done_2 === 1'b1) dones++;
      tick();
      exp = (i < 3) ? i : 3;
      total++; if (instr_count_2 !== CNT_W2'(exp)) begin
        bad++;
        $display("FAIL sat_count nop%0d got %0d expected %0d", i, instr_count_2, exp);
      end
      $display("txn sat nop%0d count=%0d", i, instr_count_2);
    end
    total++; if (dones != 5) begin
      bad++; $display("FAIL sat_done_pulses got %0d expected 5", dones);
    end
  endtask

  task automatic test_random();
    logic [15:0] x;
    int kind;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        total++; if ({if0.in_ready, wr, done} !== 3'b100) begin
          bad++;
          $display("FAIL rand_idle got rdy/wr/done=%b expected 100", {if0.in_ready, wr, done});
        end
      end
      x = 16'($urandom);
      kind = $urandom_range(0, 2);
      x[15:14] = 2'(kind);
      test_instr(x, 1'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1;
    reset2 = 1'b1;
    if0.in_valid = 1'b0;
    if0.instr = 16'h0000;
    if2.in_valid = 1'b0;
    if2.instr = 16'h0000;
    model_reset();
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_in_wb();
    test_nop_halt();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
